// File: rtl/pb_scan_pkg.sv
// Shared types and helpers for the pushbutton note scanner.
// Index 4'hF is reserved to mean "no note selected".
package pb_scan_pkg;

  localparam int NUM_KEYS_MAX = 15;

  typedef logic [3:0] note_idx_t;

  localparam note_idx_t NO_NOTE = 4'hF;

  // Lowest set bit index, NO_NOTE when the vector is empty.
  function automatic note_idx_t lowest_set(input logic [NUM_KEYS_MAX-1:0] v);
    note_idx_t r;
    r = NO_NOTE;
    for (int i = NUM_KEYS_MAX - 1; i >= 0; i--) begin
      if (v[i]) r = note_idx_t'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/pb_debounce_bit.sv
// One pushbutton lane: 2-FF synchroniser, tick-sampled history register,
// debounced level and a one-cycle strobe on each debounced press.
module pb_debounce_bit #(
  parameter int DB_SAMPLES = 4
) (
  input  logic clk,
  input  logic nrst,
  input  logic i_tick,
  input  logic i_pb_raw,
  output logic o_pb_db,
  output logic o_pb_rise
);

  logic                  r_sync1;
  logic                  r_sync2;
  logic [DB_SAMPLES-1:0] r_hist;
  logic                  r_db;
  logic                  r_rise;
  logic                  w_all_ones;
  logic                  w_all_zeros;

  assign w_all_ones  = &r_hist;
  assign w_all_zeros = ~|r_hist;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= '0;
      r_db    <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_sync1 <= i_pb_raw;
      r_sync2 <= r_sync1;
      if (i_tick) r_hist <= {r_hist[DB_SAMPLES-2:0], r_sync2};
      // Strobe fires only on the cycle the debounced level first goes high.
      r_rise <= w_all_ones & ~r_db;
      if (w_all_ones)       r_db <= 1'b1;
      else if (w_all_zeros) r_db <= 1'b0;
    end
  end

  assign o_pb_db   = r_db;
  assign o_pb_rise = r_rise;

endmodule

// File: rtl/pb_note_scanner.sv
// Pushbutton input stage: per-key debounce plus last-pressed-wins note select.
// Define PB_NOTE_LATCH_EN to keep the last note selected after all keys release.
module pb_note_scanner
  import pb_scan_pkg::*;
#(
  parameter int NUM_KEYS   = 15,
  parameter int TICK_DIV   = 10000,
  parameter int DB_SAMPLES = 4
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic [NUM_KEYS-1:0] pb,
  output logic [NUM_KEYS-1:0] pb_db,
  output logic [NUM_KEYS-1:0] pb_rise,
  output logic                note_valid,
  output logic [3:0]          note_idx
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0]        r_tick_cnt;
  logic                    w_tick;
  note_idx_t               r_note_idx;
  logic                    r_note_valid;
  note_idx_t               w_note_nxt;
  logic                    w_valid_nxt;
  logic [NUM_KEYS_MAX-1:0] w_rise_ext;
  logic [NUM_KEYS_MAX-1:0] w_db_ext;
  logic [15:0]             w_db_wide;
  logic                    w_held_dropped;

  assign w_tick = (r_tick_cnt == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)       r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    pb_debounce_bit #(
      .DB_SAMPLES(DB_SAMPLES)
    ) u_key (
      .clk      (clk),
      .nrst     (nrst),
      .i_tick   (w_tick),
      .i_pb_raw (pb[g]),
      .o_pb_db  (pb_db[g]),
      .o_pb_rise(pb_rise[g])
    );
  end

  assign w_rise_ext = NUM_KEYS_MAX'(pb_rise);
  assign w_db_ext   = NUM_KEYS_MAX'(pb_db);
  // Widened so the NO_NOTE index reads a constant zero instead of going out of range.
  assign w_db_wide      = 16'(pb_db);
  assign w_held_dropped = r_note_valid & ~w_db_wide[r_note_idx];

  always_comb begin
    w_note_nxt  = r_note_idx;
    w_valid_nxt = r_note_valid;
    if (|pb_rise) begin
      w_note_nxt  = lowest_set(w_rise_ext);
      w_valid_nxt = 1'b1;
    end else if (w_held_dropped) begin
      if (|pb_db) begin
        w_note_nxt  = lowest_set(w_db_ext);
        w_valid_nxt = 1'b1;
      end else begin
`ifdef PB_NOTE_LATCH_EN
        w_note_nxt  = r_note_idx;
        w_valid_nxt = r_note_valid;
`else
        w_note_nxt  = NO_NOTE;
        w_valid_nxt = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_note_idx   <= NO_NOTE;
      r_note_valid <= 1'b0;
    end else begin
      r_note_idx   <= w_note_nxt;
      r_note_valid <= w_valid_nxt;
    end
  end

  assign note_idx   = r_note_idx;
  assign note_valid = r_note_valid;

endmodule
